// File: rtl/rv32_trace_streamer_pkg.sv
// Shared types for the retire-trace streamer: record layout, word order, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional feature macro: TRACE_SEQ_EN. When defined, each record carries a 32-bit
// sequence number and is emitted as 4 words. Otherwise it is emitted as 3 words.
package rv32_trace_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   // Word index codes, in emission order
   localparam logic [1:0] W_PC     = 2'd0;
   localparam logic [1:0] W_INSTR  = 2'd1;
   localparam logic [1:0] W_RESULT = 2'd2;

`ifdef TRACE_SEQ_EN
   localparam logic [1:0] W_SEQ = 2'd3;
   localparam int TRACE_WORDS = 4;
   localparam int REC_W       = 128;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] result;
      logic [31:0] seq;
   } trace_rec_t;
`else
   localparam int TRACE_WORDS = 3;
   localparam int REC_W       = 96;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] result;
   } trace_rec_t;
`endif

   localparam logic [1:0] LAST_IDX = 2'(TRACE_WORDS - 1);

   // Select one 32-bit word of a record by its index code
   function automatic logic [31:0] rec_word(input trace_rec_t rec, input logic [1:0] idx);
      case (idx)
         W_PC:     rec_word = rec.pc;
         W_INSTR:  rec_word = rec.instr;
         W_RESULT: rec_word = rec.result;
`ifdef TRACE_SEQ_EN
         W_SEQ:    rec_word = rec.seq;
`endif
         default:  rec_word = 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/rv32_trace_streamer_fifo.sv
// Generic DEPTH x W record FIFO with occupancy count.
// Latency: write visible on rdata the cycle after push into an empty FIFO.
// Backpressure: caller must gate push with !full and pop with !empty.
//
// Ports:
//   clk, reset (async, active-low)
//   push/wdata   write one entry at the rising edge
//   pop/rdata    rdata shows the head entry; pop advances past it
//   full, empty  status derived from the registered level
//   level        entries currently stored, 0..DEPTH
module rv32_trace_streamer_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 96
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/rv32_trace_streamer.sv
// Captures {pc, instr, result} per retired instruction and streams it as 32-bit words.
// Latency: record pushed at edge N into an idle, empty streamer -> m_valid high after N+2.
// Backpressure: m_ready low holds the current word; FIFO overflow drops records and counts them.
//
// Optional feature macro: TRACE_SEQ_EN (adds a per-record sequence word, 4 words/record).
//
// Ports:
//   clk, reset          clock, async active-low reset
//   retire_valid/pc/instr/result   retire tap from the core
//   m_valid/m_data/m_last/m_ready  word stream to the debug bridge
//   fifo_level          records buffered, excluding the one being sent
//   drop_count          saturating count of records lost to a full FIFO
module rv32_trace_streamer
   import rv32_trace_streamer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DCW   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     retire_valid,
   input  logic [31:0]              retire_pc,
   input  logic [31:0]              retire_instr,
   input  logic [31:0]              retire_result,
   output logic                     m_valid,
   output logic [31:0]              m_data,
   output logic                     m_last,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [DCW-1:0]           drop_count
);

   trace_rec_t wr_rec;
   trace_rec_t rd_rec;
   trace_rec_t shadow;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   state_t     state;
   logic [1:0] idx;
   logic [1:0] idx_nxt;

   // Full comes from registered level, so a same-cycle pop never makes room for a push
   assign push    = retire_valid & ~full;
   assign idx_nxt = idx + 2'd1;

`ifdef TRACE_SEQ_EN
   logic [31:0] seq_cnt;

   // Counts every retire, including dropped ones, so gaps expose losses downstream
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) seq_cnt <= '0;
      else if (retire_valid) seq_cnt <= seq_cnt + 32'd1;
   end

   always_comb begin
      wr_rec        = '0;
      wr_rec.pc     = retire_pc;
      wr_rec.instr  = retire_instr;
      wr_rec.result = retire_result;
      wr_rec.seq    = seq_cnt;
   end
`else
   always_comb begin
      wr_rec        = '0;
      wr_rec.pc     = retire_pc;
      wr_rec.instr  = retire_instr;
      wr_rec.result = retire_result;
   end
`endif

   // Pop in IDLE to start a record, or on acceptance of the last word to chain without a bubble
   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:    pop = ~empty;
         SEND:    pop = m_valid & m_ready & (idx == LAST_IDX) & ~empty;
         default: pop = 1'b0;
      endcase
   end

   rv32_trace_streamer_fifo #(
      .DEPTH (DEPTH),
      .W     (REC_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (wr_rec),
      .pop   (pop),
      .rdata (rd_rec),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shadow  <= '0;
         idx     <= W_PC;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  shadow <= rd_rec;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               state   <= SEND;
               idx     <= W_PC;
               m_valid <= 1'b1;
               m_data  <= shadow.pc;
               m_last  <= 1'b0;
            end
            SEND: begin
               if (m_ready) begin
                  if (idx == LAST_IDX) begin
                     if (!empty) begin
                        shadow <= rd_rec;
                        idx    <= W_PC;
                        m_data <= rd_rec.pc;
                        m_last <= 1'b0;
                     end else begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                     end
                  end else begin
                     idx    <= idx_nxt;
                     m_data <= rec_word(shadow, idx_nxt);
                     m_last <= (idx_nxt == LAST_IDX);
                  end
               end
            end
            default: begin
               state   <= IDLE;
               m_valid <= 1'b0;
               m_last  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_count <= '0;
      else if (retire_valid && full && !(&drop_count)) drop_count <= drop_count + 1'b1;
   end

endmodule

// File: tb/tb_rv32_trace_streamer.sv
// Directed bench for rv32_trace_streamer: reset, latency, backpressure, overflow, drain order.
// Inputs change and outputs are sampled on the falling edge.
// Works for both builds; the sequence-word scenario is compiled only with TRACE_SEQ_EN.
module tb_rv32_trace_streamer;

   localparam int DEPTH = 8;
   localparam int DCW   = 16;
`ifdef TRACE_SEQ_EN
   localparam int NW = 4;
`else
   localparam int NW = 3;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        retire_valid = 1'b0;
   logic [31:0] retire_pc = '0;
   logic [31:0] retire_instr = '0;
   logic [31:0] retire_result = '0;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_last;
   logic        m_ready = 1'b0;
   logic [3:0]  fifo_level;
   logic [DCW-1:0] drop_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rv32_trace_streamer #(.DEPTH(DEPTH), .DCW(DCW)) dut (
      .clk           (clk),
      .reset         (reset),
      .retire_valid  (retire_valid),
      .retire_pc     (retire_pc),
      .retire_instr  (retire_instr),
      .retire_result (retire_result),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_ready       (m_ready),
      .fifo_level    (fifo_level),
      .drop_count    (drop_count)
   );

   // Expected {m_valid, m_last, m_data} for word w of a record
   function automatic logic [33:0] exp_w(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic [31:0] res, input logic [31:0] seq,
                                         input int w);
      logic [31:0] d;
      case (w)
         0:       d = pc;
         1:       d = instr;
         2:       d = res;
         default: d = seq;
      endcase
      return {1'b1, (w == NW - 1), d};
   endfunction

   task automatic test_reset;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b want=0", m_valid); else n_pass++;
      n_chk++; if (m_last !== 1'b0) $display("FAIL reset_m_last got=%b want=0", m_last); else n_pass++;
      n_chk++; if (m_data !== 32'h0) $display("FAIL reset_m_data got=%h want=0", m_data); else n_pass++;
      n_chk++; if (fifo_level !== 4'd0) $display("FAIL reset_level got=%0d want=0", fifo_level); else n_pass++;
      n_chk++; if (drop_count !== '0) $display("FAIL reset_drops got=%0d want=0", drop_count); else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL post_reset_idle got=%b want=0", m_valid); else n_pass++;
   endtask

   task automatic test_reset_mid_send;
      m_ready = 1'b1;
      retire_valid = 1'b1; retire_pc = 32'hA0; retire_instr = 32'h11; retire_result = 32'h22;
      @(negedge clk);
      retire_pc = 32'hB0; retire_instr = 32'h33; retire_result = 32'h44;
      @(negedge clk);
      retire_valid = 1'b0;
      @(negedge clk);
      n_chk++; if ({m_valid, m_data} !== {1'b1, 32'hA0}) $display("FAIL mid_send_pc got=%b/%h want=1/000000a0", m_valid, m_data); else n_pass++;
      @(negedge clk);
      n_chk++; if (m_data !== 32'h11) $display("FAIL mid_send_instr got=%h want=00000011", m_data); else n_pass++;
      n_chk++; if (fifo_level !== 4'd1) $display("FAIL mid_send_level got=%0d want=1", fifo_level); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b want=0", m_valid); else n_pass++;
      n_chk++; if (fifo_level !== 4'd0) $display("FAIL mid_rst_level got=%0d want=0", fifo_level); else n_pass++;
      n_chk++; if ({m_last, m_data} !== 33'h0) $display("FAIL mid_rst_data got=%b/%h want=0/0", m_last, m_data); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL no_partial_after_rst got=%b want=0", m_valid); else n_pass++;
   endtask

   task automatic test_single;
      m_ready = 1'b1;
      retire_valid = 1'b1; retire_pc = 32'h10; retire_instr = 32'h00500093; retire_result = 32'h5;
      @(negedge clk);
      retire_valid = 1'b0;
      n_chk++; if (m_valid !== 1'b0) $display("FAIL single_lat1 got=%b want=0", m_valid); else n_pass++;
      @(negedge clk);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL single_lat2 got=%b want=0", m_valid); else n_pass++;
      for (int w = 0; w < NW; w++) begin
         @(negedge clk);
         n_chk++;
         if ({m_valid, m_last, m_data} !== exp_w(32'h10, 32'h00500093, 32'h5, 32'd0, w))
            $display("FAIL single_word%0d got=%b/%b/%h want=%h", w, m_valid, m_last, m_data,
                     exp_w(32'h10, 32'h00500093, 32'h5, 32'd0, w));
         else n_pass++;
      end
      @(negedge clk);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL single_end got=%b want=0", m_valid); else n_pass++;
   endtask

   task automatic test_backpressure;
      m_ready = 1'b1;
      retire_valid = 1'b1; retire_pc = 32'h20; retire_instr = 32'h00500093; retire_result = 32'h7;
      @(negedge clk);
      retire_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if ({m_valid, m_data} !== {1'b1, 32'h20}) $display("FAIL bp_pc got=%b/%h want=1/00000020", m_valid, m_data); else n_pass++;
      @(negedge clk);
      m_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if ({m_valid, m_last, m_data} !== {2'b10, 32'h00500093})
            $display("FAIL bp_hold%0d got=%b/%b/%h want=1/0/00500093", k, m_valid, m_last, m_data);
         else n_pass++;
         @(negedge clk);
      end
      n_chk++; if (m_data !== 32'h00500093) $display("FAIL bp_hold_last got=%h want=00500093", m_data); else n_pass++;
      m_ready = 1'b1;
      for (int w = 2; w < NW; w++) begin
         @(negedge clk);
         n_chk++;
         if ({m_valid, m_last, m_data} !== exp_w(32'h20, 32'h00500093, 32'h7, 32'd1, w))
            $display("FAIL bp_word%0d got=%b/%b/%h want=%h", w, m_valid, m_last, m_data,
                     exp_w(32'h20, 32'h00500093, 32'h7, 32'd1, w));
         else n_pass++;
      end
      @(negedge clk);
      n_chk++; if (m_valid !== 1'b0) $display("FAIL bp_end got=%b want=0", m_valid); else n_pass++;
   endtask

   // 12 retires with the link stalled: one record goes to the shadow register, 8 fill the FIFO
   task automatic test_overflow;
      m_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         retire_valid  = 1'b1;
         retire_pc     = 32'h100 + 32'(4 * i);
         retire_instr  = 32'h1000 + 32'(i);
         retire_result = 32'h2000 + 32'(i);
         @(negedge clk);
         if (i == 7) begin
            n_chk++; if (fifo_level !== 4'd7) $display("FAIL ovf_level7 got=%0d want=7", fifo_level); else n_pass++;
         end
         if (i == 8) begin
            n_chk++; if ({fifo_level, drop_count} !== {4'd8, 16'd0}) $display("FAIL ovf_full got=%0d/%0d want=8/0", fifo_level, drop_count); else n_pass++;
         end
      end
      retire_valid = 1'b0;
      n_chk++; if (fifo_level !== 4'd8) $display("FAIL ovf_level got=%0d want=8", fifo_level); else n_pass++;
      n_chk++; if (drop_count !== 16'd3) $display("FAIL ovf_drops got=%0d want=3", drop_count); else n_pass++;
      n_chk++; if ({m_valid, m_data} !== {1'b1, 32'h100}) $display("FAIL ovf_head got=%b/%h want=1/00000100", m_valid, m_data); else n_pass++;
   endtask

   // Push lands on the same edge as the pop of the next record: still dropped
   task automatic test_push_pop_full;
      logic found;
      found = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 8 && !found; k++) begin
         @(negedge clk);
         if (m_last) found = 1'b1;
      end
      n_chk++; if (found !== 1'b1) $display("FAIL ppf_last_timeout got=%b want=1", found); else n_pass++;
      retire_valid = 1'b1; retire_pc = 32'hDEAD; retire_instr = 32'hBEEF; retire_result = 32'h1;
      @(negedge clk);
      retire_valid = 1'b0;
      n_chk++; if (fifo_level !== 4'd7) $display("FAIL ppf_level got=%0d want=7", fifo_level); else n_pass++;
      n_chk++; if (drop_count !== 16'd4) $display("FAIL ppf_drops got=%0d want=4", drop_count); else n_pass++;
   endtask

   task automatic test_drain;
      m_ready = 1'b1;
      for (int r = 1; r <= 8; r++) begin
         for (int w = 0; w < NW; w++) begin
            n_chk++;
            if ({m_valid, m_last, m_data} !== exp_w(32'h100 + 32'(4 * r), 32'h1000 + 32'(r),
                                                  32'h2000 + 32'(r), 32'(2 + r), w))
               $display("FAIL drain_r%0d_w%0d got=%b/%b/%h want=%h", r, w, m_valid, m_last, m_data,
                        exp_w(32'h100 + 32'(4 * r), 32'h1000 + 32'(r), 32'h2000 + 32'(r), 32'(2 + r), w));
            else n_pass++;
            @(negedge clk);
         end
      end
      n_chk++; if ({m_valid, fifo_level} !== 5'd0) $display("FAIL drain_end got=%b/%0d want=0/0", m_valid, fifo_level); else n_pass++;
   endtask

`ifdef TRACE_SEQ_EN
   // Overflow with a fresh counter: seq 9 and 10 are dropped, the next record carries 11
   task automatic test_seq;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_ready = 1'b0;
      for (int i = 0; i < 11; i++) begin
         retire_valid  = 1'b1;
         retire_pc     = 32'h300 + 32'(4 * i);
         retire_instr  = 32'h3000 + 32'(i);
         retire_result = 32'h4000 + 32'(i);
         @(negedge clk);
      end
      retire_valid = 1'b0;
      n_chk++; if ({fifo_level, drop_count} !== {4'd8, 16'd2}) $display("FAIL seq_fill got=%0d/%0d want=8/2", fifo_level, drop_count); else n_pass++;
      m_ready = 1'b1;
      for (int r = 0; r <= 8; r++) begin
         for (int w = 0; w < NW; w++) begin
            n_chk++;
            if ({m_valid, m_last, m_data} !== exp_w(32'h300 + 32'(4 * r), 32'h3000 + 32'(r),
                                                  32'h4000 + 32'(r), 32'(r), w))
               $display("FAIL seq_r%0d_w%0d got=%b/%b/%h", r, w, m_valid, m_last, m_data);
            else n_pass++;
            @(negedge clk);
         end
      end
      retire_valid = 1'b1; retire_pc = 32'h400; retire_instr = 32'h5000; retire_result = 32'h6000;
      @(negedge clk);
      retire_valid = 1'b0;
      repeat (2) @(negedge clk);
      for (int w = 0; w < NW; w++) begin
         n_chk++;
         if ({m_valid, m_last, m_data} !== exp_w(32'h400, 32'h5000, 32'h6000, 32'd11, w))
            $display("FAIL seq_gap_w%0d got=%b/%b/%h", w, m_valid, m_last, m_data);
         else n_pass++;
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid_send();
      test_single();
      test_backpressure();
      test_overflow();
      test_push_pop_full();
      test_drain();
`ifdef TRACE_SEQ_EN
      test_seq();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
